// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle control unit
package mc_ctrl_pkg;

  // FSM state encodings (4-bit, IDLE must stay 0 for the debug port)
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE   = 4'd0;
  localparam state_t ST_FETCH  = 4'd1;
  localparam state_t ST_DECODE = 4'd2;
  localparam state_t ST_MEMADR = 4'd3;
  localparam state_t ST_MEMRD  = 4'd4;
  localparam state_t ST_MEMWB  = 4'd5;
  localparam state_t ST_MEMWR  = 4'd6;
  localparam state_t ST_REXEC  = 4'd7;
  localparam state_t ST_RWB    = 4'd8;
  localparam state_t ST_BRANCH = 4'd9;
  localparam state_t ST_ORIEX  = 4'd10;
  localparam state_t ST_ORIWB  = 4'd11;
  localparam state_t ST_JUMP   = 4'd12;
  localparam state_t ST_TRAP   = 4'd13;

  // ALU operation select
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_OR    = 2'b11
  } alu_op_e;

  // ALU B operand select
  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_e;

  // PC source select
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_EXC    = 2'b11
  } pc_src_e;

  // Default opcode encodings
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_J     = 6'h02;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - Moore output decode from state, with memory-ready gating
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zext,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic       instr_done
);

  // Every output defaults low so IDLE and unused encodings drive nothing
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    zext          = 1'b0;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal       = 1'b0;
    instr_done    = 1'b0;
    case (state)
      ST_FETCH: begin
        // IR and PC only latch in the cycle the fetch actually completes
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      ST_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      ST_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        zext      = 1'b1;
        alu_op    = ALU_OR;
      end
      ST_ORIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      ST_TRAP: begin
        illegal    = 1'b1;
        pc_write   = 1'b1;
        pc_source  = PCSRC_EXC;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle control FSM: state register and next-state logic
module mc_control
  import mc_ctrl_pkg::*;
#(
  parameter int            OPW      = 6,
  parameter logic [OPW-1:0] OP_RTYPE = OPW'(OPC_RTYPE),
  parameter logic [OPW-1:0] OP_LW    = OPW'(OPC_LW),
  parameter logic [OPW-1:0] OP_SW    = OPW'(OPC_SW),
  parameter logic [OPW-1:0] OP_BEQ   = OPW'(OPC_BEQ),
  parameter logic [OPW-1:0] OP_ORI   = OPW'(OPC_ORI),
  parameter logic [OPW-1:0] OP_J     = OPW'(OPC_J)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic           zext,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           illegal,
  output logic           instr_done,
  output logic [3:0]     state_o
);

  state_t state;
  state_t state_nx;
  logic   is_load;

  // State register; reset drops straight to IDLE so no strobe survives the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Load/store choice is frozen in DECODE so later opcode changes are harmless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load <= 1'b0;
    end else if (state == ST_DECODE) begin
      is_load <= (opcode == OP_LW);
    end
  end

  // Next-state selection; memory states hold until mem_ready
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:   state_nx = ST_FETCH;
      ST_FETCH:  state_nx = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (opcode == OP_RTYPE) begin
          state_nx = ST_REXEC;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_nx = ST_MEMADR;
        end else if (opcode == OP_BEQ) begin
          state_nx = ST_BRANCH;
        end else if (opcode == OP_ORI) begin
          state_nx = ST_ORIEX;
        end else if (opcode == OP_J) begin
          state_nx = ST_JUMP;
        end else begin
          state_nx = ST_TRAP;
        end
      end
      ST_MEMADR: state_nx = is_load ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  state_nx = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  state_nx = ST_FETCH;
      ST_MEMWR:  state_nx = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_REXEC:  state_nx = ST_RWB;
      ST_RWB:    state_nx = ST_FETCH;
      ST_BRANCH: state_nx = ST_FETCH;
      ST_ORIEX:  state_nx = ST_ORIWB;
      ST_ORIWB:  state_nx = ST_FETCH;
      ST_JUMP:   state_nx = ST_FETCH;
      ST_TRAP:   state_nx = ST_FETCH;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign state_o = state;

  mc_ctrl_outdec u_outdec (
    .state         (state),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .zext          (zext),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal       (illegal),
    .instr_done    (instr_done)
  );

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed self-checking bench for mc_control
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, zext, illegal, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  mc_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .zext          (zext),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal       (illegal),
    .instr_done    (instr_done),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  // Observed control word: pw,pwc,iord,mrd,mwr,irw,m2r,rdst,rw,asa,asb[2],zext,aop[2],psrc[2],ill,done
  logic [18:0] ctl;
  assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, zext, alu_op, pc_source,
                illegal, instr_done};

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_REXEC = 4'd7;
  localparam logic [3:0] S_RWB = 4'd8, S_BRANCH = 4'd9, S_ORIEX = 4'd10, S_ORIWB = 4'd11;
  localparam logic [3:0] S_JUMP = 4'd12, S_TRAP = 4'd13;

  //                                 pw   pwc  iord mrd  mwr  irw  m2r  rdst rw   asa  asb   zx   aop   psrc  ill  done
  localparam logic [18:0] E_ZERO    = '0;
  localparam logic [18:0] E_FETCH_W = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_FETCH_R = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_MEMRD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1};
  localparam logic [18:0] E_MEMWR_W = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_MEMWR_R = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1};
  localparam logic [18:0] E_REXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b10,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_RWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1};
  localparam logic [18:0] E_BRANCH  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,2'b01,1'b0,1'b1};
  localparam logic [18:0] E_ORIEX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,2'b11,2'b00,1'b0,1'b0};
  localparam logic [18:0] E_ORIWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1};
  localparam logic [18:0] E_JUMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b10,1'b0,1'b1};
  localparam logic [18:0] E_TRAP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b11,1'b1,1'b1};

  localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, ORI = 6'h0D, JMP = 6'h02;

  // One row per clock cycle: inputs applied in that cycle, expected state and control word
  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] ex;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(input logic [5:0] op, input logic rdy,
                              input logic [3:0] st, input logic [18:0] ex);
    row_t r;
    r.op = op; r.rdy = rdy; r.st = st; r.ex = ex;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (state_o !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", state_o, S_IDLE);
    end
    n_cmp++;
    if (ctl !== E_ZERO) begin
      n_err++;
      $display("FAIL reset_outputs: got %05h want %05h", ctl, E_ZERO);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (state_o !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_release_idle: got %0d want %0d", state_o, S_IDLE);
    end
  endtask

  task automatic test_lw();
    rows.delete();
    rows.push_back(mk(LW, 1'b1, S_FETCH,  E_FETCH_R));
    rows.push_back(mk(LW, 1'b1, S_DECODE, E_DECODE));
    rows.push_back(mk(SW, 1'b1, S_MEMADR, E_MEMADR));
    rows.push_back(mk(SW, 1'b1, S_MEMRD,  E_MEMRD));
    rows.push_back(mk(SW, 1'b1, S_MEMWB,  E_MEMWB));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #2;
      opcode = rows[i].op; mem_ready = rows[i].rdy; #1;
      n_cmp++;
      if (state_o !== rows[i].st) begin
        n_err++;
        $display("FAIL lw[%0d] state: got %0d want %0d", i, state_o, rows[i].st);
      end
      n_cmp++;
      if (ctl !== rows[i].ex) begin
        n_err++;
        $display("FAIL lw[%0d] ctl: got %05h want %05h", i, ctl, rows[i].ex);
      end
    end
  endtask

  task automatic test_sw_wait();
    rows.delete();
    rows.push_back(mk(SW, 1'b1, S_FETCH,  E_FETCH_R));
    rows.push_back(mk(SW, 1'b0, S_DECODE, E_DECODE));
    rows.push_back(mk(LW, 1'b1, S_MEMADR, E_MEMADR));
    rows.push_back(mk(LW, 1'b0, S_MEMWR,  E_MEMWR_W));
    rows.push_back(mk(LW, 1'b0, S_MEMWR,  E_MEMWR_W));
    rows.push_back(mk(LW, 1'b0, S_MEMWR,  E_MEMWR_W));
    rows.push_back(mk(LW, 1'b1, S_MEMWR,  E_MEMWR_R));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #2;
      opcode = rows[i].op; mem_ready = rows[i].rdy; #1;
      n_cmp++;
      if (state_o !== rows[i].st) begin
        n_err++;
        $display("FAIL sw_wait[%0d] state: got %0d want %0d", i, state_o, rows[i].st);
      end
      n_cmp++;
      if (ctl !== rows[i].ex) begin
        n_err++;
        $display("FAIL sw_wait[%0d] ctl: got %05h want %05h", i, ctl, rows[i].ex);
      end
    end
  endtask

  task automatic test_fetch_wait();
    rows.delete();
    rows.push_back(mk(RT, 1'b0, S_FETCH,  E_FETCH_W));
    rows.push_back(mk(RT, 1'b0, S_FETCH,  E_FETCH_W));
    rows.push_back(mk(RT, 1'b1, S_FETCH,  E_FETCH_R));
    rows.push_back(mk(RT, 1'b0, S_DECODE, E_DECODE));
    rows.push_back(mk(RT, 1'b0, S_REXEC,  E_REXEC));
    rows.push_back(mk(RT, 1'b0, S_RWB,    E_RWB));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #2;
      opcode = rows[i].op; mem_ready = rows[i].rdy; #1;
      n_cmp++;
      if (state_o !== rows[i].st) begin
        n_err++;
        $display("FAIL fetch_wait[%0d] state: got %0d want %0d", i, state_o, rows[i].st);
      end
      n_cmp++;
      if (ctl !== rows[i].ex) begin
        n_err++;
        $display("FAIL fetch_wait[%0d] ctl: got %05h want %05h", i, ctl, rows[i].ex);
      end
    end
  endtask

  task automatic test_trap();
    rows.delete();
    rows.push_back(mk(6'h3F, 1'b1, S_FETCH,  E_FETCH_R));
    rows.push_back(mk(6'h3F, 1'b1, S_DECODE, E_DECODE));
    rows.push_back(mk(6'h3F, 1'b1, S_TRAP,   E_TRAP));
    rows.push_back(mk(JMP,   1'b1, S_FETCH,  E_FETCH_R));
    rows.push_back(mk(JMP,   1'b1, S_DECODE, E_DECODE));
    rows.push_back(mk(JMP,   1'b1, S_JUMP,   E_JUMP));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #2;
      opcode = rows[i].op; mem_ready = rows[i].rdy; #1;
      n_cmp++;
      if (state_o !== rows[i].st) begin
        n_err++;
        $display("FAIL trap[%0d] state: got %0d want %0d", i, state_o, rows[i].st);
      end
      n_cmp++;
      if (ctl !== rows[i].ex) begin
        n_err++;
        $display("FAIL trap[%0d] ctl: got %05h want %05h", i, ctl, rows[i].ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    rows.delete();
    rows.push_back(mk(RT,  1'b1, S_FETCH,  E_FETCH_R));
    rows.push_back(mk(RT,  1'b1, S_DECODE, E_DECODE));
    rows.push_back(mk(RT,  1'b1, S_REXEC,  E_REXEC));
    rows.push_back(mk(RT,  1'b1, S_RWB,    E_RWB));
    rows.push_back(mk(BEQ, 1'b1, S_FETCH,  E_FETCH_R));
    rows.push_back(mk(BEQ, 1'b1, S_DECODE, E_DECODE));
    rows.push_back(mk(JMP, 1'b1, S_BRANCH, E_BRANCH));
    rows.push_back(mk(ORI, 1'b1, S_FETCH,  E_FETCH_R));
    rows.push_back(mk(ORI, 1'b1, S_DECODE, E_DECODE));
    rows.push_back(mk(ORI, 1'b1, S_ORIEX,  E_ORIEX));
    rows.push_back(mk(ORI, 1'b1, S_ORIWB,  E_ORIWB));
    rows.push_back(mk(JMP, 1'b1, S_FETCH,  E_FETCH_R));
    rows.push_back(mk(JMP, 1'b1, S_DECODE, E_DECODE));
    rows.push_back(mk(JMP, 1'b1, S_JUMP,   E_JUMP));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #2;
      opcode = rows[i].op; mem_ready = rows[i].rdy; #1;
      n_cmp++;
      if (state_o !== rows[i].st) begin
        n_err++;
        $display("FAIL b2b[%0d] state: got %0d want %0d", i, state_o, rows[i].st);
      end
      n_cmp++;
      if (ctl !== rows[i].ex) begin
        n_err++;
        $display("FAIL b2b[%0d] ctl: got %05h want %05h", i, ctl, rows[i].ex);
      end
    end
  endtask

  task automatic test_reset_mid();
    rows.delete();
    rows.push_back(mk(LW, 1'b1, S_FETCH,  E_FETCH_R));
    rows.push_back(mk(LW, 1'b1, S_DECODE, E_DECODE));
    rows.push_back(mk(LW, 1'b1, S_MEMADR, E_MEMADR));
    rows.push_back(mk(LW, 1'b0, S_MEMRD,  E_MEMRD));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #2;
      opcode = rows[i].op; mem_ready = rows[i].rdy; #1;
      n_cmp++;
      if (state_o !== rows[i].st) begin
        n_err++;
        $display("FAIL rst_mid[%0d] state: got %0d want %0d", i, state_o, rows[i].st);
      end
      n_cmp++;
      if (ctl !== rows[i].ex) begin
        n_err++;
        $display("FAIL rst_mid[%0d] ctl: got %05h want %05h", i, ctl, rows[i].ex);
      end
    end
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== S_IDLE) begin
      n_err++;
      $display("FAIL rst_mid_async_state: got %0d want %0d", state_o, S_IDLE);
    end
    n_cmp++;
    if (ctl !== E_ZERO) begin
      n_err++;
      $display("FAIL rst_mid_async_ctl: got %05h want %05h", ctl, E_ZERO);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (state_o !== S_IDLE) begin
      n_err++;
      $display("FAIL rst_mid_release_c1: got %0d want %0d", state_o, S_IDLE);
    end
    @(posedge clk); #2;
    n_cmp++;
    if (state_o !== S_FETCH) begin
      n_err++;
      $display("FAIL rst_mid_release_c2: got %0d want %0d", state_o, S_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_fetch_wait();
    test_trap();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle successor to the single-cycle main decoder: one opcode is decoded per instruction, and a Moore FSM sequences the datapath over 3–5 cycles.
- Sits between the instruction register and the shared multicycle datapath (PC, IR, MDR, A/B, ALUOut).
- Adds wait-state handshakes to a single unified memory and an illegal-opcode trap.
- Opcode width and encodings are parametrised.

Parameters:
- OPW, 6, opcode field width.
- OP_RTYPE, 6'h00, R-format opcode.
- OP_LW, 6'h23, load word.
- OP_SW, 6'h2B, store word.
- OP_BEQ, 6'h04, branch if equal.
- OP_ORI, 6'h0D, OR immediate (zero-extended).
- OP_J, 6'h02, jump.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPW  IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back select: 1 = MDR.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- reg_write  out  1  register-file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- zext  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = or.
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset: the asynchronous assertion of rst_n low forces state IDLE. All outputs are 0 while in IDLE, and state_o = 0. The cycle after rst_n deasserts, the FSM enters FETCH.
- Outputs are decoded from the state; the signals marked (r) below are additionally ANDed with mem_ready.
- FETCH:
  - Asserts mem_read, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write(r) and pc_write(r) are gated by mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - Asserts alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut).
  - Next state by opcode: RTYPE → REXEC; LW/SW → MEMADR; BEQ → BRANCH; ORI → ORIEX; J → JUMP; any other value → TRAP.
- MEMADR: alu_src_a = 1, alu_src_b = 10, zext = 0, alu_op = 00. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read, iord = 1. Waits while mem_ready = 0, then goes to MEMWB.
- MEMWB: reg_write, mem_to_reg = 1, reg_dst = 0, instr_done. Then FETCH.
- MEMWR: mem_write, iord = 1, instr_done(r). Waits while mem_ready = 0, then goes to FETCH.
- REXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Then RWB.
- RWB: reg_write, reg_dst = 1, mem_to_reg = 0, instr_done. Then FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond, pc_source = 01, instr_done. Then FETCH.
- ORIEX: alu_src_a = 1, alu_src_b = 10, zext = 1, alu_op = 11. Then ORIWB.
- ORIWB: reg_write, reg_dst = 0, mem_to_reg = 0, instr_done. Then FETCH.
- JUMP: pc_write, pc_source = 10, instr_done. Then FETCH.
- TRAP: illegal, pc_write, pc_source = 11, instr_done. Then FETCH.
- Latency with mem_ready tied high:
  - R-format: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - ORI: 4 cycles.
  - J: 3 cycles.
  - Illegal opcode: 3 cycles.
  - Each cycle of mem_ready = 0 in FETCH, MEMRD or MEMWR adds 1 cycle.
- mem_read and mem_write are never asserted together.
- In a memory state, the request stays high and its address select (iord) stays stable until mem_ready is seen.
- mem_ready outside a memory state is ignored.
- An opcode change after DECODE has no effect; the branch target is chosen in DECODE only.
- rst_n asserted mid-instruction: IDLE immediately. No partial write strobe is emitted after the reset edge.
- The default state assignment returns to IDLE on any unreachable encoding.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit: IDLE = 0, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BRANCH, ORIEX, ORIWB, JUMP, TRAP);
  - alu_op encodings;
  - alu_src_b encodings;
  - pc_source encodings;
  - default opcode constants.
- One combinational sub-module, mc_ctrl_outdec, maps (state, mem_ready) to all datapath outputs.
- mc_control keeps the state register and next-state logic.

Test Plan:
- Reset then LW with mem_ready = 1: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write = 1 with mem_to_reg = 1 in cycle 5; instr_done pulses once.
- SW with mem_ready low for 3 cycles in MEMWR: mem_write held 4 cycles with iord = 1; instr_done only in the ready cycle; no reg_write.
- FETCH with mem_ready low for 2 cycles: ir_write and pc_write = 0 until the ready cycle, then both = 1 for exactly one cycle.
- Opcode 6'h3F: TRAP reached in cycle 3 with illegal = 1, pc_write = 1, pc_source = 11; FETCH next.
- R-format, BEQ, ORI, J back-to-back: check alu_op 10/01/11, zext = 1 only in ORIEX, pc_source = 10 in JUMP; latencies 4/3/4/3.
- rst_n pulsed low asynchronously in MEMRD: all outputs 0 before the next clock edge; FETCH in the second cycle after release.
